// File: rtl/complex_div_seq.sv
// Sequential complex divider q = a*conj(b)/|b|^2 with valid/ready on both sides.
// Define COMPLEX_DIV_SAT_EN to saturate quotients instead of wrapping them.
module complex_div_seq #(
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned FRAC_BITS = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [DATA_SIZE-1:0] i_data_a_i,
  input  logic [DATA_SIZE-1:0] i_data_a_q,
  input  logic [DATA_SIZE-1:0] i_data_b_i,
  input  logic [DATA_SIZE-1:0] i_data_b_q,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [DATA_SIZE-1:0] o_data_i,
  output logic [DATA_SIZE-1:0] o_data_q,
  output logic                 o_div_zero
);

  localparam int unsigned N  = 2 * DATA_SIZE + 1;
  localparam int unsigned KW = N + FRAC_BITS;
  localparam int unsigned CW = $clog2(KW + 1);

  typedef enum logic [1:0] {StIdle, StMult, StDiv, StDone} state_e;

  state_e               state_q, state_d;
  logic [DATA_SIZE-1:0] a_i_q, a_i_d, a_q_q, a_q_d, b_i_q, b_i_d, b_q_q, b_q_d;
  logic                 neg_re_q, neg_re_d, neg_im_q, neg_im_d;
  logic [N-1:0]         den_q, den_d, rem_re_q, rem_re_d, rem_im_q, rem_im_d;
  logic [KW-1:0]        quo_re_q, quo_re_d, quo_im_q, quo_im_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_SIZE-1:0] out_i_q, out_i_d, out_q_q, out_q_d;
  logic                 div_zero_q, div_zero_d;

  logic signed [N-1:0] xa_i, xa_q, xb_i, xb_q, num_re, num_im;
  logic [N-1:0]        den, mag_re, mag_im;
  logic [N+KW-1:0]     step_re, step_im;

`ifdef COMPLEX_DIV_SAT_EN
  localparam logic [DATA_SIZE-1:0] MaxPos = {1'b0, {(DATA_SIZE-1){1'b1}}};

  function automatic logic [DATA_SIZE-1:0] narrow(input logic neg, input logic [KW-1:0] mag);
    logic [DATA_SIZE-1:0] m;
    m = (mag > KW'(MaxPos)) ? MaxPos : mag[DATA_SIZE-1:0];
    return neg ? -m : m;
  endfunction

  // Division by zero saturates toward the sign of the numerator sample.
  function automatic logic [DATA_SIZE-1:0] zero_val(input logic [DATA_SIZE-1:0] a);
    if (a == '0) return '0;
    return a[DATA_SIZE-1] ? -MaxPos : MaxPos;
  endfunction
`else
  function automatic logic [DATA_SIZE-1:0] narrow(input logic neg,
                                                  input logic [DATA_SIZE-1:0] mag);
    return neg ? -mag : mag;
  endfunction
`endif

  // One restoring-division step: returns {remainder, shifted quotient}.
  function automatic logic [N+KW-1:0] div_step(input logic [N-1:0] rem,
                                               input logic [KW-1:0] quo,
                                               input logic [N-1:0] dv);
    logic [N:0]   sh;
    logic [N-1:0] diff;
    logic         ge;
    sh   = {rem, quo[KW-1]};
    ge   = (sh >= {1'b0, dv});
    diff = sh[N-1:0] - dv;
    return {(ge ? diff : sh[N-1:0]), quo[KW-2:0], ge};
  endfunction

  always_comb begin
    xa_i   = {{(N-DATA_SIZE){a_i_q[DATA_SIZE-1]}}, a_i_q};
    xa_q   = {{(N-DATA_SIZE){a_q_q[DATA_SIZE-1]}}, a_q_q};
    xb_i   = {{(N-DATA_SIZE){b_i_q[DATA_SIZE-1]}}, b_i_q};
    xb_q   = {{(N-DATA_SIZE){b_q_q[DATA_SIZE-1]}}, b_q_q};
    num_re = xa_i * xb_i + xa_q * xb_q;
    num_im = xa_q * xb_i - xa_i * xb_q;
    den    = xb_i * xb_i + xb_q * xb_q;
    mag_re = num_re[N-1] ? -num_re : num_re;
    mag_im = num_im[N-1] ? -num_im : num_im;
    step_re = div_step(rem_re_q, quo_re_q, den_q);
    step_im = div_step(rem_im_q, quo_im_q, den_q);
  end

  always_comb begin
    state_d    = state_q;
    a_i_d      = a_i_q;
    a_q_d      = a_q_q;
    b_i_d      = b_i_q;
    b_q_d      = b_q_q;
    neg_re_d   = neg_re_q;
    neg_im_d   = neg_im_q;
    den_d      = den_q;
    rem_re_d   = rem_re_q;
    rem_im_d   = rem_im_q;
    quo_re_d   = quo_re_q;
    quo_im_d   = quo_im_q;
    cnt_d      = cnt_q;
    out_i_d    = out_i_q;
    out_q_d    = out_q_q;
    div_zero_d = div_zero_q;
    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          a_i_d   = i_data_a_i;
          a_q_d   = i_data_a_q;
          b_i_d   = i_data_b_i;
          b_q_d   = i_data_b_q;
          state_d = StMult;
        end
      end
      StMult: begin
        den_d    = den;
        neg_re_d = num_re[N-1];
        neg_im_d = num_im[N-1];
        rem_re_d = '0;
        rem_im_d = '0;
        quo_re_d = KW'(mag_re) << FRAC_BITS;
        quo_im_d = KW'(mag_im) << FRAC_BITS;
        cnt_d    = '0;
        if (den == '0) begin
`ifdef COMPLEX_DIV_SAT_EN
          out_i_d = zero_val(a_i_q);
          out_q_d = zero_val(a_q_q);
`else
          out_i_d = '0;
          out_q_d = '0;
`endif
          div_zero_d = 1'b1;
          state_d    = StDone;
        end else begin
          state_d = StDiv;
        end
      end
      StDiv: begin
        rem_re_d = step_re[N+KW-1:KW];
        rem_im_d = step_im[N+KW-1:KW];
        quo_re_d = step_re[KW-1:0];
        quo_im_d = step_im[KW-1:0];
        cnt_d    = cnt_q + 1'b1;
        // Last step: narrow the freshly completed quotient straight into the output regs.
        if (cnt_q == CW'(KW - 1)) begin
`ifdef COMPLEX_DIV_SAT_EN
          out_i_d = narrow(neg_re_q, step_re[KW-1:0]);
          out_q_d = narrow(neg_im_q, step_im[KW-1:0]);
`else
          out_i_d = narrow(neg_re_q, step_re[DATA_SIZE-1:0]);
          out_q_d = narrow(neg_im_q, step_im[DATA_SIZE-1:0]);
`endif
          state_d = StDone;
        end
      end
      StDone: begin
        if (i_ready) begin
          div_zero_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= StIdle;
      a_i_q      <= '0;
      a_q_q      <= '0;
      b_i_q      <= '0;
      b_q_q      <= '0;
      neg_re_q   <= 1'b0;
      neg_im_q   <= 1'b0;
      den_q      <= '0;
      rem_re_q   <= '0;
      rem_im_q   <= '0;
      quo_re_q   <= '0;
      quo_im_q   <= '0;
      cnt_q      <= '0;
      out_i_q    <= '0;
      out_q_q    <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_i_q      <= a_i_d;
      a_q_q      <= a_q_d;
      b_i_q      <= b_i_d;
      b_q_q      <= b_q_d;
      neg_re_q   <= neg_re_d;
      neg_im_q   <= neg_im_d;
      den_q      <= den_d;
      rem_re_q   <= rem_re_d;
      rem_im_q   <= rem_im_d;
      quo_re_q   <= quo_re_d;
      quo_im_q   <= quo_im_d;
      cnt_q      <= cnt_d;
      out_i_q    <= out_i_d;
      out_q_q    <= out_q_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign o_ready    = (state_q == StIdle);
  assign o_valid    = (state_q == StDone);
  assign o_data_i   = out_i_q;
  assign o_data_q   = out_q_q;
  assign o_div_zero = div_zero_q;

endmodule
